pci_bus_arbiter: RTL and testbench

Central PCI bus arbiter that shares the bus among up to N_MASTERS initiators using the standard REQn/GNTn handshake. It watches FRAMEn/IRDYn to track bus ownership and applies round-robin fairness, an idle-grant timeout and optional bus parking. It sits beside the target logic on the PCI backplane and owns grant sequencing for all masters.

---
 rtl/pci_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: central PCI bus arbiter with round-robin fairness,
// an idle-grant timeout and optional parking on the last owner.
//
// Ports:
//   CLK      bus clock, all logic on rising edge
//   RST      synchronous, active-high reset
//   REQn     active-low bus requests, bit i = master i
//   FRAMEn   PCI FRAME#, sampled
//   IRDYn    PCI IRDY#, sampled
//   GNTn     active-low grants, registered, at most one bit low
//   Owner    index of current/last grantee (registered)
//   BusBusy  high while the arbiter is in BUSY (registered)
module pci_bus_arbiter #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned TIMEOUT   = 16,
    parameter bit          PARK_EN   = 1'b1,
    localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] REQn,
    input  logic                 FRAMEn,
    input  logic                 IRDYn,
    output logic [N_MASTERS-1:0] GNTn,
    output logic [OW-1:0]        Owner,
    output logic                 BusBusy
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_GNT,
        S_BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_n_d;
    logic [OW-1:0]          owner_d;
    logic [OW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   granted_q, granted_d;

    logic                   bus_idle_c;
    logic                   any_req_c;
    logic                   own_req_c;
    logic                   others_req_c;
    logic                   parked_c;
    logic                   hi_hit_c, lo_hit_c;
    logic [OW-1:0]          hi_idx_c, lo_idx_c;
    logic [OW-1:0]          winner_c;

    // Active-low grant vector selecting a single master
    function automatic logic [N_MASTERS-1:0] gnt_for(input logic [OW-1:0] idx);
        gnt_for = ~(N_MASTERS'(1) << idx);
    endfunction

    // Index increment modulo N_MASTERS
    function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] idx);
        if (idx == OW'(N_MASTERS - 1)) begin
            inc_mod = '0;
        end else begin
            inc_mod = idx + OW'(1);
        end
    endfunction

    assign bus_idle_c   = FRAMEn & IRDYn;
    assign any_req_c    = ~(&REQn);
    assign own_req_c    = ~REQn[Owner];
    assign others_req_c = |(~REQn & gnt_for(Owner));
    assign parked_c     = ~GNTn[Owner];

    // Round-robin winner: lowest requester at or above Ptr, else lowest below it
    always_comb begin
        hi_hit_c = 1'b0;
        lo_hit_c = 1'b0;
        hi_idx_c = '0;
        lo_idx_c = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (!REQn[i]) begin
                if (i >= int'(ptr_q)) begin
                    hi_hit_c = 1'b1;
                    hi_idx_c = OW'(i);
                end else begin
                    lo_hit_c = 1'b1;
                    lo_idx_c = OW'(i);
                end
            end
        end
        winner_c = hi_hit_c ? hi_idx_c : lo_idx_c;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        gnt_n_d   = GNTn;
        owner_d   = Owner;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        granted_d = granted_q;

        case (state_q)
            S_IDLE: begin
                if (!any_req_c) begin
                    // Parking only once someone has actually owned the bus
                    gnt_n_d = (PARK_EN && granted_q) ? gnt_for(Owner) : '1;
                end else if (bus_idle_c) begin
                    if ((winner_c == Owner) && parked_c) begin
                        // Parked master re-requests: grant already low, no turnaround
                        state_d = S_GNT;
                        cnt_d   = '0;
                    end else begin
                        owner_d = winner_c;
                        gnt_n_d = '1;
                        state_d = S_GAP;
                    end
                end else begin
                    gnt_n_d = '1;
                end
            end

            S_GAP: begin
                gnt_n_d   = gnt_for(Owner);
                cnt_d     = '0;
                granted_d = 1'b1;
                state_d   = S_GNT;
            end

            S_GNT: begin
                if (!FRAMEn) begin
                    // Transaction start beats both withdrawal and timeout
                    state_d = S_BUSY;
                    ptr_d   = inc_mod(Owner);
                end else if (!own_req_c) begin
                    state_d = S_IDLE;
                    gnt_n_d = '1;
                end else if (bus_idle_c) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        gnt_n_d = '1;
                        ptr_d   = inc_mod(Owner);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_BUSY: begin
                // Any competing request pulls the grant so the owner yields
                gnt_n_d = (own_req_c && !others_req_c) ? gnt_for(Owner) : '1;
                if (bus_idle_c) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_n_d = '1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            GNTn      <= '1;
            Owner     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            granted_q <= 1'b0;
            BusBusy   <= 1'b0;
        end else begin
            state_q   <= state_d;
            GNTn      <= gnt_n_d;
            Owner     <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            granted_q <= granted_d;
            BusBusy   <= (state_d == S_BUSY);
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed per-cycle vectors with hand-computed grant,
// owner and busy values, followed by random stimulus checking grant safety.
module tb_pci_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQn = 4'b1111;
    logic       FRAMEn = 1'b1;
    logic       IRDYn = 1'b1;
    logic [3:0] GNTn;
    logic [1:0] Owner;
    logic       BusBusy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pci_bus_arbiter #(
        .N_MASTERS(4),
        .TIMEOUT  (16),
        .PARK_EN  (1'b1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQn   (REQn),
        .FRAMEn (FRAMEn),
        .IRDYn  (IRDYn),
        .GNTn   (GNTn),
        .Owner  (Owner),
        .BusBusy(BusBusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then check registered outputs after the edge
    task automatic vec(input string tag, input logic [3:0] req, input logic f, input logic i,
                       input logic [3:0] eg, input logic [1:0] eo, input logic eb);
        REQn   = req;
        FRAMEn = f;
        IRDYn  = i;
        @(posedge CLK);
        #1;
        check({tag, ".gnt"},  32'(GNTn),    32'(eg));
        check({tag, ".own"},  32'(Owner),   32'(eo));
        check({tag, ".busy"}, 32'(BusBusy), 32'(eb));
    endtask

    logic [3:0] prev_gnt;

    initial begin
        // Reset held with every master requesting
        RST = 1'b1;
        for (int k = 0; k < 3; k++) vec("rst", 4'b0000, 1, 1, 4'b1111, 2'd0, 0);
        RST = 1'b0;

        // First grant to master 0 via one turnaround cycle
        vec("m0_gap",   4'b0000, 1, 1, 4'b1111, 2'd0, 0);
        vec("m0_gnt",   4'b1110, 1, 1, 4'b1110, 2'd0, 0);
        vec("m0_drop",  4'b1111, 1, 1, 4'b1111, 2'd0, 0);
        vec("m0_park",  4'b1111, 1, 1, 4'b1110, 2'd0, 0);

        // Masters 1 and 3 alternate, each running a 3-cycle transaction
        vec("rr1_gap",  4'b0101, 1, 1, 4'b1111, 2'd1, 0);
        vec("rr1_gnt",  4'b0101, 1, 1, 4'b1101, 2'd1, 0);
        vec("rr1_b0",   4'b0101, 0, 0, 4'b1101, 2'd1, 1);
        vec("rr1_b1",   4'b0101, 0, 0, 4'b1111, 2'd1, 1);
        vec("rr1_b2",   4'b0101, 0, 0, 4'b1111, 2'd1, 1);
        vec("rr1_end",  4'b0101, 1, 1, 4'b1111, 2'd1, 0);
        vec("rr3_gap",  4'b0101, 1, 1, 4'b1111, 2'd3, 0);
        vec("rr3_gnt",  4'b0101, 1, 1, 4'b0111, 2'd3, 0);
        vec("rr3_b0",   4'b0101, 0, 0, 4'b0111, 2'd3, 1);
        vec("rr3_b1",   4'b0101, 0, 0, 4'b1111, 2'd3, 1);
        vec("rr3_b2",   4'b0101, 0, 0, 4'b1111, 2'd3, 1);
        vec("rr3_end",  4'b0101, 1, 1, 4'b1111, 2'd3, 0);
        vec("rr1b_gap", 4'b0101, 1, 1, 4'b1111, 2'd1, 0);
        vec("rr1b_gnt", 4'b0101, 1, 1, 4'b1101, 2'd1, 0);

        // Master 2 granted but idle: grant low for exactly 16 cycles
        vec("to_drop1", 4'b1111, 1, 1, 4'b1111, 2'd1, 0);
        vec("to_gap",   4'b1011, 1, 1, 4'b1111, 2'd2, 0);
        vec("to_gnt",   4'b1011, 1, 1, 4'b1011, 2'd2, 0);
        for (int k = 0; k < 15; k++) vec("to_hold", 4'b1010, 1, 1, 4'b1011, 2'd2, 0);
        vec("to_expire", 4'b1010, 1, 1, 4'b1111, 2'd2, 0);
        vec("to_m0_gap", 4'b1010, 1, 1, 4'b1111, 2'd0, 0);
        vec("to_m0_gnt", 4'b1010, 1, 1, 4'b1110, 2'd0, 0);

        // Preemption of master 0 while FRAMEn is still low
        vec("pre_b0",   4'b1110, 0, 0, 4'b1110, 2'd0, 1);
        vec("pre_b1",   4'b1110, 0, 0, 4'b1110, 2'd0, 1);
        vec("pre_req2", 4'b1010, 0, 0, 4'b1111, 2'd0, 1);
        vec("pre_last", 4'b1010, 1, 0, 4'b1111, 2'd0, 1);
        vec("pre_end",  4'b1010, 1, 1, 4'b1111, 2'd0, 0);
        vec("pre_gap",  4'b1010, 1, 1, 4'b1111, 2'd2, 0);
        vec("pre_gnt2", 4'b1010, 1, 1, 4'b1011, 2'd2, 0);

        // Parking on master 1, re-request without gap, then handover to master 3
        vec("pk_drop2", 4'b1111, 1, 1, 4'b1111, 2'd2, 0);
        vec("pk_gap1",  4'b1101, 1, 1, 4'b1111, 2'd1, 0);
        vec("pk_gnt1",  4'b1101, 1, 1, 4'b1101, 2'd1, 0);
        vec("pk_b0",    4'b1101, 0, 0, 4'b1101, 2'd1, 1);
        vec("pk_b1",    4'b1111, 0, 0, 4'b1111, 2'd1, 1);
        vec("pk_end",   4'b1111, 1, 1, 4'b1111, 2'd1, 0);
        vec("pk_park",  4'b1111, 1, 1, 4'b1101, 2'd1, 0);
        vec("pk_stay",  4'b1111, 1, 1, 4'b1101, 2'd1, 0);
        vec("pk_nogap", 4'b1101, 1, 1, 4'b1101, 2'd1, 0);
        vec("pk_drop1", 4'b1111, 1, 1, 4'b1111, 2'd1, 0);
        vec("pk_park2", 4'b1111, 1, 1, 4'b1101, 2'd1, 0);
        vec("pk_gap3",  4'b0111, 1, 1, 4'b1111, 2'd3, 0);
        vec("pk_gnt3",  4'b0111, 1, 1, 4'b0111, 2'd3, 0);

        // FRAMEn falls on the same edge the timeout would expire: BUSY wins
        for (int k = 0; k < 15; k++) vec("sim_hold", 4'b0111, 1, 1, 4'b0111, 2'd3, 0);
        vec("sim_busy",  4'b0111, 0, 0, 4'b0111, 2'd3, 1);
        vec("sim_end",   4'b0111, 1, 1, 4'b0111, 2'd3, 0);
        vec("sim_regnt", 4'b0111, 1, 1, 4'b0111, 2'd3, 0);
        // Owner REQn rises on the edge FRAMEn falls: still BUSY
        vec("sim_req_frame", 4'b1111, 0, 0, 4'b0111, 2'd3, 1);
        vec("sim_req_drop",  4'b1111, 0, 0, 4'b1111, 2'd3, 1);

        // Reset in the middle of BUSY
        RST = 1'b1;
        vec("rst_busy", 4'b0000, 0, 0, 4'b1111, 2'd0, 0);
        RST = 1'b0;
        vec("rst_after", 4'b1111, 1, 1, 4'b1111, 2'd0, 0);

        // Random stimulus: at most one grant, never a direct grant handover
        prev_gnt = GNTn;
        for (int k = 0; k < 10000; k++) begin
            REQn   = 4'($urandom);
            FRAMEn = 1'($urandom);
            IRDYn  = 1'($urandom);
            @(posedge CLK);
            #1;
            check("rand_onehot", 32'($countones(~GNTn) <= 1), 32'd1);
            if (prev_gnt != 4'b1111 && GNTn != 4'b1111) check("rand_move", 32'(GNTn), 32'(prev_gnt));
            prev_gnt = GNTn;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
